// File: rtl/mult_div_unit.sv
// Iterative MIPS-style multiply/divide unit producing HI/LO for MULT/MULTU/DIV/DIVU.
// Ports:
//   clock, reset (sync, active-high)
//   start, op[1:0], rs_data, rt_data   -> operation request
//   mthi, mtlo, wdata                  -> direct HI/LO writes
//   busy, done, hi, lo                 -> status and result registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t               state;
    logic [CW-1:0]        count;
    logic                 is_div;
    logic                 neg_q;
    logic                 neg_r;
    logic                 div_zero;
    logic [WIDTH-1:0]     opnd_b;
    logic [WIDTH-1:0]     orig_a;
    logic [2*WIDTH-1:0]   acc;

    // Operand preparation: signed ops run on magnitudes.
    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        sgn   = ~op[0];
        a_neg = sgn & rs_data[WIDTH-1];
        b_neg = sgn & rt_data[WIDTH-1];
        a_mag = a_neg ? -rs_data : rs_data;
        b_mag = b_neg ? -rt_data : rt_data;
    end

    // One iteration step. acc = {upper, lower}:
    //   multiply: upper = partial product, lower = remaining multiplier bits
    //   divide:   upper = partial remainder, lower = dividend/quotient bits
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc[0] ? opnd_b : '0)};
        div_part = acc[2*WIDTH-1:WIDTH-1];
        div_ge   = div_part >= {1'b0, opnd_b};
        // When div_ge holds the difference is below the divisor, so it fits.
        div_diff = div_part[WIDTH-1:0] - opnd_b;
        if (is_div) begin
            acc_next = {(div_ge ? div_diff : div_part[WIDTH-1:0]),
                        acc[WIDTH-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction of the final magnitudes.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            count    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            opnd_b   <= '0;
            orig_a   <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mthi) hi <= wdata;
                    if (mtlo) lo <= wdata;
                    if (start) begin
                        is_div   <= op[1];
                        neg_q    <= a_neg ^ b_neg;
                        neg_r    <= a_neg & op[1];
                        div_zero <= op[1] & (rt_data == '0);
                        orig_a   <= rs_data;
                        count    <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                        if (op[1]) begin
                            opnd_b <= b_mag;
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                        end else begin
                            opnd_b <= a_mag;
                            acc    <= {{WIDTH{1'b0}}, b_mag};
                        end
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + CW'(1);
                    if (count == LAST) state <= FINISH;
                end
                FINISH: begin
                    if (!is_div) begin
                        hi <= prod[2*WIDTH-1:WIDTH];
                        lo <= prod[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= orig_a;
                        lo <= '1;
                    end else begin
                        hi <= rem;
                        lo <= quo;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit (WIDTH=32).
// Drives directed vectors and checks HI/LO, busy/done timing with assertions.
module tb_mult_div_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int passed = 0;
    int total  = 0;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Ticks until done is seen (bounded); n = edges taken, nb = busy samples.
    task automatic wait_done(output int n, output int nb);
        n  = 0;
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (busy) nb++;
            if (done) break;
        end
        if (!done) chk("wait_done_timeout", 64'(done), 64'd1);
    endtask

    // Issues a start at the next edge (E0) and waits for completion.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        int nb;
        op      = o;
        rs_data = a;
        rt_data = b;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("done_low_at_start", 64'(done), 64'd0);
        wait_done(n, nb);
    endtask

    initial begin
        int n;
        int nb;
        int pulses;
        reset   = 1'b1;
        start   = 1'b0;
        op      = MULT;
        rs_data = '0;
        rt_data = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        wdata   = '0;
        tick();
        tick();
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b0;
        tick();

        // MULT -30 * 56 with latency and pulse-width checks.
        op      = MULT;
        rs_data = 32'hFFFF_FFE2;
        rt_data = 32'd56;
        start   = 1'b1;
        tick();
        start = 1'b0;
        chk("mult_busy_e0", 64'(busy), 64'd1);
        wait_done(n, nb);
        chk("mult_latency", 64'(n), 64'd33);
        chk("mult_busy_cycles", 64'(nb + 1), 64'd33);
        chk("mult_busy_low_done", 64'(busy), 64'd0);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_F970);
        tick();
        chk("mult_done_one_cycle", 64'(done), 64'd0);

        // MULTU max*max, then DIVU back-to-back at the done-clearing edge.
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        chk("multu_latency", 64'(n), 64'd33);
        chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo), 64'h0000_0001);
        run_op(DIVU, 32'd100, 32'd7, n);
        chk("divu_latency", 64'(n), 64'd33);
        chk("divu_lo", 64'(lo), 64'd14);
        chk("divu_hi", 64'(hi), 64'd2);

        // Signed divide: -30 / 56, then most-negative / -1.
        run_op(DIV, 32'hFFFF_FFE2, 32'd56, n);
        chk("div_lo", 64'(lo), 64'd0);
        chk("div_hi", 64'(hi), 64'hFFFF_FFE2);
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        chk("div_ovf_lo", 64'(lo), 64'h8000_0000);
        chk("div_ovf_hi", 64'(hi), 64'd0);

        // Signed divide with a negative dividend and divisor: -7 / -2 = 3 r -1.
        run_op(DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, n);
        chk("div_neg_lo", 64'(lo), 64'd3);
        chk("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);

        // Signed divide by zero keeps the dividend as given.
        run_op(DIV, 32'hFFFF_FF00, 32'd0, n);
        chk("div0s_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0s_hi", 64'(hi), 64'hFFFF_FF00);

        // Unsigned divide by zero.
        run_op(DIVU, 32'h0000_1234, 32'd0, n);
        chk("div0_latency", 64'(n), 64'd33);
        chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("div0_hi", 64'(hi), 64'h0000_1234);

        // MULT 3*4 with start and mthi pulses while busy.
        op      = MULT;
        rs_data = 32'd3;
        rt_data = 32'd4;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) tick();
        op      = DIV;
        rs_data = 32'd9;
        rt_data = 32'd3;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 6; i < 10; i++) tick();
        mthi  = 1'b1;
        wdata = 32'h0000_AAAA;
        tick();
        mthi = 1'b0;
        chk("busy_hold_hi", 64'(hi), 64'h0000_1234);
        chk("busy_hold_lo", 64'(lo), 64'hFFFF_FFFF);
        chk("busy_mid_run", 64'(busy), 64'd1);
        wait_done(n, nb);
        chk("ignored_latency", 64'(n + 10), 64'd33);
        chk("ignored_hi", 64'(hi), 64'd0);
        chk("ignored_lo", 64'(lo), 64'd12);
        tick();

        // mtlo in IDLE takes effect at the next edge.
        mtlo  = 1'b1;
        wdata = 32'h0000_0055;
        tick();
        mtlo = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h55);
        chk("mtlo_hi_kept", 64'(hi), 64'd0);

        // mthi together with start in IDLE: write applied, start accepted.
        mthi    = 1'b1;
        wdata   = 32'h0000_BEEF;
        op      = MULTU;
        rs_data = 32'd5;
        rt_data = 32'd6;
        start   = 1'b1;
        tick();
        mthi  = 1'b0;
        start = 1'b0;
        chk("mthi_with_start_hi", 64'(hi), 64'h0000_BEEF);
        chk("mthi_with_start_busy", 64'(busy), 64'd1);
        wait_done(n, nb);
        chk("mthi_with_start_res_hi", 64'(hi), 64'd0);
        chk("mthi_with_start_res_lo", 64'(lo), 64'd30);
        tick();

        // MULTU 7*9 aborted by reset at cycle 20.
        op      = MULTU;
        rs_data = 32'd7;
        rt_data = 32'd9;
        start   = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        chk("abort_lo_held", 64'(lo), 64'd0);
        run_op(MULTU, 32'd7, 32'd9, n);
        chk("after_reset_latency", 64'(n), 64'd33);
        chk("after_reset_lo", 64'(lo), 64'd63);
        chk("after_reset_hi", 64'(hi), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the RS/RT operand pair and produces MIPS-style HI/LO results for MULT, MULTU, DIV and DIVU.
- Writeback reads HI/LO for MFHI/MFLO; MTHI/MTLO write them directly.
- The unit is multi-cycle. Control stalls on `busy`.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits. Latency scales as WIDTH+1.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high
- start  input  1  request operation; sampled only when idle
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- rs_data  input  WIDTH  operand A (multiplicand / dividend)
- rt_data  input  WIDTH  operand B (multiplier / divisor)
- mthi  input  1  write wdata into HI
- mtlo  input  1  write wdata into LO
- wdata  input  WIDTH  data for MTHI/MTLO
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset, synchronous, active-high:
  - hi=0, lo=0, busy=0, done=0, state=IDLE.
  - An in-flight operation is aborted with no HI/LO update.
  - Reset has priority over every other input.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 at edge E0 latches op and operands.
  - For signed ops, operands are converted to magnitudes and the result signs are recorded.
  - Iteration counter is cleared; busy=1 from E0; transition to RUN.
- RUN:
  - One bit per cycle for WIDTH cycles, at edges E1..E(WIDTH).
  - Multiply uses shift-add into a 2*WIDTH accumulator.
  - Divide uses restoring shift-subtract, yielding quotient and remainder.
  - After the WIDTH-th iteration, go to FINISH.
- FINISH, at edge E(WIDTH+1):
  - Apply sign correction and write hi/lo.
  - done=1, busy=0, go to IDLE.
  - done returns to 0 at the next edge.
  - For WIDTH=32, start at E0 gives results and done=1 after E33.
- A new start may be accepted at the edge where done clears, giving back-to-back operation every WIDTH+2 cycles.
- Signed rules:
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B).
  - Remainder takes the sign of the dividend.
  - Results are truncated to WIDTH bits.
- Divide by zero (rt_data=0): full latency still applies; lo=all ones; hi=dividend as given (unmodified rs_data).
- Signed overflow (most-negative / -1): lo=most-negative value (0x80000000), hi=0. This falls out of the magnitude algorithm naturally.
- start while busy: ignored; operands are not re-latched.
- mthi/mtlo:
  - In IDLE, hi/lo are written at the next edge.
  - While busy, they are ignored.
  - If start and mthi/mtlo occur at the same edge in IDLE, the write is applied and start is also accepted. The later completion overwrites hi/lo.
- hi/lo hold their value during RUN until FINISH. MFHI/MFLO issued while busy see the old values; stalling is the control unit's job.
- Undefined op bits are not possible (2-bit op fully decoded).

Test Plan:
- MULT, rs=-30 (0xFFFFFFE2), rt=56 -> done exactly 33 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFF970; busy high for 33 cycles; done high for 1 cycle.
- MULTU, rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 100/7 -> lo=14, hi=2.
- DIV, rs=-30, rt=56 -> lo=0, hi=0xFFFFFFE2. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU, rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234, latency unchanged.
- Start MULT 3*4; pulse start with DIV 9/3 at cycle 5 and mthi with 0xAAAA at cycle 10 -> both ignored; hi=0, lo=12. Then in IDLE: mtlo 0x55 -> lo=0x55 next edge.
- Start MULTU 7*9; assert reset at cycle 20 -> hi=lo=0, busy=0, no done pulse. A new start after reset completes normally: lo=63.
